pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 144 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: picks one of four pixel generators and cross-fades
// between them by stepping brightness down to zero, switching generator,
// and stepping brightness back up. Advances on a button edge or after a
// programmable number of frames when auto-advance is enabled.
module pattern_sequencer #(
    parameter int HOLD_FRAMES = 240,
    parameter int FADE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_frame,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic [5:0] pat_rgb0,
    input  logic [5:0] pat_rgb1,
    input  logic [5:0] pat_rgb2,
    input  logic [5:0] pat_rgb3,
    output logic [5:0] rgb,
    output logic [1:0] pat_sel,
    output logic [1:0] level,
    output logic       busy
);

    localparam logic [1:0] SHOW     = 2'd0;
    localparam logic [1:0] FADE_OUT = 2'd1;
    localparam logic [1:0] FADE_IN  = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0] FADE_LAST = 4'(FADE_FRAMES - 1);

    logic [1:0] state_q,    state_d;
    logic [1:0] pat_sel_q,  pat_sel_d;
    logic [1:0] level_q,    level_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] fade_cnt_q, fade_cnt_d;
    logic       pending_q,  pending_d;
    logic       btn_q;
    logic       busy_q;

    logic       btn_edge;
    logic       trigger;
    logic       fade_term;
    logic [5:0] sel_rgb;

    assign btn_edge  = btn_next & ~btn_q;
    assign trigger   = pending_q | (auto_en & (hold_cnt_q == HOLD_LAST));
    assign fade_term = (fade_cnt_q == FADE_LAST);

    // Next-state logic: button edges latch a request at any time, everything
    // else moves only on the frame-start pulse. Clearing the request on a
    // SHOW->FADE_OUT transition wins over a coincident new edge so a press
    // landing on the same frame as auto expiry yields a single advance.
    always_comb begin
        state_d    = state_q;
        pat_sel_d  = pat_sel_q;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;
        fade_cnt_d = fade_cnt_q;
        pending_d  = pending_q | btn_edge;
        if (next_frame) begin
            case (state_q)
                SHOW: begin
                    if (trigger) begin
                        state_d    = FADE_OUT;
                        hold_cnt_d = 8'd0;
                        fade_cnt_d = 4'd0;
                        pending_d  = 1'b0;
                    end else if (auto_en) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                FADE_OUT: begin
                    if (fade_term) begin
                        fade_cnt_d = 4'd0;
                        if (level_q != 2'd0) begin
                            level_d = level_q - 2'd1;
                        end else begin
                            pat_sel_d = pat_sel_q + 2'd1;
                            state_d   = FADE_IN;
                        end
                    end else begin
                        fade_cnt_d = fade_cnt_q + 4'd1;
                    end
                end
                FADE_IN: begin
                    if (fade_term) begin
                        fade_cnt_d = 4'd0;
                        level_d    = level_q + 2'd1;
                        if (level_q == 2'd2) begin
                            state_d    = SHOW;
                            hold_cnt_d = 8'd0;
                        end
                    end else begin
                        fade_cnt_d = fade_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = SHOW;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to full brightness on generator 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SHOW;
            pat_sel_q  <= 2'd0;
            level_q    <= 2'd3;
            hold_cnt_q <= 8'd0;
            fade_cnt_q <= 4'd0;
            pending_q  <= 1'b0;
            btn_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_sel_q  <= pat_sel_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            pending_q  <= pending_d;
            btn_q      <= btn_next;
            busy_q     <= (state_d != SHOW);
        end
    end

    // Pixel path: choose the active generator, then clamp each channel to level.
    always_comb begin
        case (pat_sel_q)
            2'd0:    sel_rgb = pat_rgb0;
            2'd1:    sel_rgb = pat_rgb1;
            2'd2:    sel_rgb = pat_rgb2;
            default: sel_rgb = pat_rgb3;
        endcase
        rgb[5:4] = (sel_rgb[5:4] > level_q) ? level_q : sel_rgb[5:4];
        rgb[3:2] = (sel_rgb[3:2] > level_q) ? level_q : sel_rgb[3:2];
        rgb[1:0] = (sel_rgb[1:0] > level_q) ? level_q : sel_rgb[1:0];
    end

    assign pat_sel = pat_sel_q;
    assign level   = level_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer with short hold/fade timing.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       next_frame = 1'b0;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic [5:0] pat_rgb0 = 6'b101101;
    logic [5:0] pat_rgb1 = 6'b111001;
    logic [5:0] pat_rgb2 = 6'b000111;
    logic [5:0] pat_rgb3 = 6'b110011;
    logic [5:0] rgb;
    logic [1:0] pat_sel;
    logic [1:0] level;
    logic       busy;

    int testsRun = 0;
    int testsFailed = 0;

    pattern_sequencer #(.HOLD_FRAMES(8), .FADE_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .next_frame(next_frame), .btn_next(btn_next),
        .auto_en(auto_en), .pat_rgb0(pat_rgb0), .pat_rgb1(pat_rgb1),
        .pat_rgb2(pat_rgb2), .pat_rgb3(pat_rgb3), .rgb(rgb),
        .pat_sel(pat_sel), .level(level), .busy(busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            next_frame = 1'b1;
            @(negedge clk);
            next_frame = 1'b0;
        end
    endtask

    task automatic press_btn;
        @(negedge clk);
        btn_next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        next_frame = 1'b0;
        btn_next = 1'b0;
        auto_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        testsRun++;
        if (level !== 2'd3) begin testsFailed++; $display("[TB] FAIL reset_level got %0d want 3", level); end
        testsRun++;
        if (pat_sel !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_pat_sel got %0d want 0", pat_sel); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        testsRun++;
        if (rgb !== 6'b101101) begin testsFailed++; $display("[TB] FAIL reset_rgb got %b want 101101", rgb); end
    endtask

    // Auto-advance from reset: 8 frames of hold, 8 frames fading out, 6 in.
    task automatic test_auto_advance;
        logic [1:0] expLevel [14];
        logic [1:0] expSel   [14];
        logic       expBusy  [14];
        logic [5:0] expRgb   [14];
        expLevel = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0,
                     2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        expSel   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                     2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        expBusy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        expRgb   = '{6'b101101, 6'b101001, 6'b101001, 6'b010101, 6'b010101, 6'b000000, 6'b000000,
                     6'b000000, 6'b000000, 6'b010101, 6'b010101, 6'b101001, 6'b101001, 6'b111001};
        do_reset();
        auto_en = 1'b1;
        run_frames(7);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL auto_hold_busy got %b want 0", busy); end
        run_frames(1);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL auto_start_busy got %b want 1", busy); end
        for (int f = 0; f < 14; f++) begin
            run_frames(1);
            testsRun++;
            if (level !== expLevel[f] || pat_sel !== expSel[f] || busy !== expBusy[f] || rgb !== expRgb[f]) begin
                testsFailed++;
                $display("[TB] FAIL auto_fade_f%0d got lvl=%0d sel=%0d busy=%b rgb=%b want lvl=%0d sel=%0d busy=%b rgb=%b",
                         f + 1, level, pat_sel, busy, rgb, expLevel[f], expSel[f], expBusy[f], expRgb[f]);
            end
        end
    endtask

    // Button-driven advances with auto off, including the 3->0 wrap.
    task automatic test_button_wrap;
        auto_en = 1'b0;
        press_btn();
        run_frames(15);
        testsRun++;
        if (pat_sel !== 2'd2 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL btn_to2 got sel=%0d busy=%b want sel=2 busy=0", pat_sel, busy); end
        press_btn();
        run_frames(15);
        testsRun++;
        if (pat_sel !== 2'd3 || rgb !== 6'b110011) begin testsFailed++; $display("[TB] FAIL btn_to3 got sel=%0d rgb=%b want sel=3 rgb=110011", pat_sel, rgb); end
        press_btn();
        run_frames(1);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL btn_wrap_start got busy=%b want 1", busy); end
        run_frames(14);
        testsRun++;
        if (pat_sel !== 2'd0 || level !== 2'd3 || busy !== 1'b0 || rgb !== 6'b101101) begin
            testsFailed++;
            $display("[TB] FAIL btn_wrap_done got sel=%0d lvl=%0d busy=%b rgb=%b want sel=0 lvl=3 busy=0 rgb=101101", pat_sel, level, busy, rgb);
        end
        run_frames(20);
        testsRun++;
        if (pat_sel !== 2'd0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL btn_idle got sel=%0d busy=%b want sel=0 busy=0", pat_sel, busy); end
    endtask

    // Several edges during a fade collapse into one extra advance.
    task automatic test_back_to_back;
        do_reset();
        press_btn();
        run_frames(1);
        run_frames(2);
        press_btn();
        press_btn();
        press_btn();
        run_frames(12);
        testsRun++;
        if (pat_sel !== 2'd1 || busy !== 1'b0 || level !== 2'd3) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first got sel=%0d busy=%b lvl=%0d want sel=1 busy=0 lvl=3", pat_sel, busy, level);
        end
        run_frames(1);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_second_start got busy=%b want 1", busy); end
        run_frames(14);
        testsRun++;
        if (pat_sel !== 2'd2 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_second_done got sel=%0d busy=%b want sel=2 busy=0", pat_sel, busy); end
        run_frames(16);
        testsRun++;
        if (pat_sel !== 2'd2 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_third got sel=%0d busy=%b want sel=2 busy=0", pat_sel, busy); end
    endtask

    // Button edge on the very frame auto expiry fires.
    task automatic test_same_frame;
        do_reset();
        auto_en = 1'b1;
        run_frames(7);
        @(negedge clk);
        next_frame = 1'b1;
        btn_next = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL same_start got busy=%b want 1", busy); end
        @(negedge clk);
        btn_next = 1'b0;
        run_frames(14);
        testsRun++;
        if (pat_sel !== 2'd1 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL same_done got sel=%0d busy=%b want sel=1 busy=0", pat_sel, busy); end
        run_frames(1);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL same_no_pending got busy=%b want 0", busy); end
        run_frames(6);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL same_hold7 got busy=%b want 0", busy); end
        run_frames(1);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL same_auto_again got busy=%b want 1", busy); end
    endtask

    // Disabling auto-advance freezes the hold count rather than clearing it.
    task automatic test_freeze;
        do_reset();
        auto_en = 1'b1;
        run_frames(5);
        auto_en = 1'b0;
        run_frames(10);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL freeze_idle got busy=%b want 0", busy); end
        auto_en = 1'b1;
        run_frames(2);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL freeze_resume got busy=%b want 0", busy); end
        run_frames(1);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL freeze_expire got busy=%b want 1", busy); end
    endtask

    // Asynchronous reset in the middle of a fade, with a request pending.
    task automatic test_reset_midfade;
        do_reset();
        press_btn();
        run_frames(1);
        press_btn();
        run_frames(4);
        testsRun++;
        if (level !== 2'd1 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midfade_pre got lvl=%0d busy=%b want lvl=1 busy=1", level, busy); end
        rst = 1'b1;
        #1;
        testsRun++;
        if (level !== 2'd3 || pat_sel !== 2'd0 || busy !== 1'b0 || rgb !== 6'b101101) begin
            testsFailed++;
            $display("[TB] FAIL midfade_rst got lvl=%0d sel=%0d busy=%b rgb=%b want lvl=3 sel=0 busy=0 rgb=101101", level, pat_sel, busy, rgb);
        end
        @(negedge clk);
        rst = 1'b0;
        run_frames(3);
        testsRun++;
        if (busy !== 1'b0 || pat_sel !== 2'd0) begin testsFailed++; $display("[TB] FAIL midfade_discard got busy=%b sel=%0d want busy=0 sel=0", busy, pat_sel); end
    endtask

    initial begin
        test_reset();
        test_auto_advance();
        test_button_wrap();
        test_back_to_back();
        test_same_frame();
        test_freeze();
        test_reset_midfade();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
